// File: rtl/udc_pkg.sv
// ---------------------------------------------------------------------------
// udc_pkg
//   Shared constants and helpers for the up/down sequence counter.
//   DIR_UP / DIR_DOWN : encoding of the dir input.
//   cnt_max(width)    : all-ones value for a counter of the given width
//                       (widths up to 64 bits).
// ---------------------------------------------------------------------------
package udc_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic logic [63:0] cnt_max(input int unsigned width);
    return (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/udc_step.sv
// ---------------------------------------------------------------------------
// udc_step
//   Combinational next-state logic for updown_seq_counter.
//   Priority: load > en > hold.
//   Config macro UDC_SATURATE_EN: when defined the count saturates at
//   0 / max and nxt_wrap is always 0; otherwise it wraps modulo 2^WIDTH.
// Ports
//   cnt      in   WIDTH  current count
//   dir      in   1      0 = up, 1 = down
//   en       in   1      count enable
//   load     in   1      load strobe
//   load_val in   WIDTH  value to load
//   nxt_cnt  out  WIDTH  next count
//   nxt_wrap out  1      next step crosses max->0 or 0->max
// ---------------------------------------------------------------------------
module udc_step
  import udc_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             dir,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] nxt_cnt,
  output logic             nxt_wrap
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_max(WIDTH));

  always_comb begin
    nxt_cnt  = cnt;
    nxt_wrap = 1'b0;
    if (load) begin
      nxt_cnt = load_val;
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (cnt == CNT_MAX) begin
`ifdef UDC_SATURATE_EN
          nxt_cnt = cnt;
`else
          nxt_cnt  = '0;
          nxt_wrap = 1'b1;
`endif
        end else begin
          nxt_cnt = cnt + WIDTH'(1);
        end
      end else begin
        if (cnt == '0) begin
`ifdef UDC_SATURATE_EN
          nxt_cnt = cnt;
`else
          nxt_cnt  = CNT_MAX;
          nxt_wrap = 1'b1;
`endif
        end else begin
          nxt_cnt = cnt - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/updown_seq_counter.sv
// ---------------------------------------------------------------------------
// updown_seq_counter
//   Parametrised up/down sequence counter with registered match flag and
//   wrap pulse. Config macro UDC_SATURATE_EN (see udc_step) selects
//   saturating instead of modulo counting.
// Parameters
//   WIDTH    counter width (>=1)
//   MATCH    count value at which y is asserted
//   RST_VAL  count value on reset
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset
//   en        in   1      count enable
//   dir       in   1      0 = up, 1 = down
//   load      in   1      synchronous load strobe
//   load_val  in   WIDTH  load value
//   cnt       out  WIDTH  registered count
//   y         out  1      registered, high while cnt == MATCH
//   wrap      out  1      registered, one-cycle pulse after a wrapping step
// ---------------------------------------------------------------------------
module updown_seq_counter #(
  parameter int unsigned      WIDTH   = 2,
  parameter logic [WIDTH-1:0] MATCH   = '1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             y,
  output logic             wrap
);

  logic [WIDTH-1:0] nxt_cnt;
  logic             nxt_wrap;

  udc_step #(.WIDTH(WIDTH)) u_step (
    .cnt      (cnt),
    .dir      (dir),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .nxt_cnt  (nxt_cnt),
    .nxt_wrap (nxt_wrap)
  );

  // y compares the next count so it lines up with cnt in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= RST_VAL;
      y    <= (RST_VAL == MATCH);
      wrap <= 1'b0;
    end else begin
      cnt  <= nxt_cnt;
      y    <= (nxt_cnt == MATCH);
      wrap <= nxt_wrap;
    end
  end

endmodule

// File: tb/tb_updown_seq_counter.sv
module tb_updown_seq_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, dir = 1'b0, load = 1'b0;
  logic [1:0] lv2 = '0;
  logic [7:0] lv8 = '0;
  logic [1:0] cnt2;
  logic [7:0] cnt8;
  logic       y2, w2, y8, w8;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // reference state
  int m_cnt2, m_cnt8;
  bit m_y2, m_w2, m_y8, m_w8;

  always #5 clk = ~clk;

  updown_seq_counter u_dut2 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_val(lv2), .cnt(cnt2), .y(y2), .wrap(w2)
  );

  updown_seq_counter #(.WIDTH(8), .MATCH(8'h80), .RST_VAL(8'h00)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_val(lv8), .cnt(cnt8), .y(y8), .wrap(w8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural step: modulus arithmetic on plain integers.
  function automatic void model_step(input int c, input int modn, input bit e,
                                     input bit d, input bit ld, input int lv,
                                     output int nc, output bit nw);
    nc = c;
    nw = 1'b0;
    if (ld) nc = lv;
    else if (e) begin
      int raw;
      raw = d ? c - 1 : c + 1;
      if (raw < 0 || raw >= modn) begin
`ifdef UDC_SATURATE_EN
        nc = c;
`else
        nc = (raw + modn) % modn;
        nw = 1'b1;
`endif
      end else nc = raw;
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".cnt2"}, 32'(cnt2), 32'(m_cnt2));
    check({tag, ".y2"},   32'(y2),   32'(m_y2));
    check({tag, ".wrap2"},32'(w2),   32'(m_w2));
    check({tag, ".cnt8"}, 32'(cnt8), 32'(m_cnt8));
    check({tag, ".y8"},   32'(y8),   32'(m_y8));
    check({tag, ".wrap8"},32'(w8),   32'(m_w8));
  endtask

  task automatic model_reset();
    m_cnt2 = 0; m_y2 = (0 == 3);    m_w2 = 1'b0;
    m_cnt8 = 0; m_y8 = (0 == 'h80); m_w8 = 1'b0;
  endtask

  // Inputs applied #1 after an edge; outputs checked #1 after the next.
  task automatic cycle(input string tag, input bit e, input bit d, input bit ld,
                       input int v2, input int v8);
    en = e; dir = d; load = ld; lv2 = 2'(v2); lv8 = 8'(v8);
    @(posedge clk);
    model_step(m_cnt2, 4,   e, d, ld, v2 & 3,    m_cnt2, m_w2);
    model_step(m_cnt8, 256, e, d, ld, v8 & 255, m_cnt8, m_w8);
    m_y2 = (m_cnt2 == 3);
    m_y8 = (m_cnt8 == 'h80);
    #1;
    check_all(tag);
  endtask

  // Asserted mid-cycle; outputs must clear without any clock edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all({tag, ".async"});
    @(posedge clk);
    #1 check_all({tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #3 check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) cycle("t1_up", 1, 0, 0, 0, 0);
    async_reset("t2_pre");
    for (int i = 0; i < 4; i++) cycle("t2_down", 1, 1, 0, 0, 0);

    cycle("t3_setup", 0, 0, 1, 1, 1);
    cycle("t3_load", 1, 1, 1, 3, 3);
    for (int i = 0; i < 3; i++) cycle("t3_hold", 0, $urandom_range(0, 1), 0, 0, 0);

    async_reset("t4_pre");
    cycle("t4_up0", 1, 0, 0, 0, 0);
    cycle("t4_up1", 1, 0, 0, 0, 0);
    async_reset("t4");
    cycle("t4_resume", 1, 0, 0, 0, 0);

    cycle("t5_ld7f", 0, 0, 1, 0, 'h7F);
    cycle("t5_up80", 1, 0, 0, 0, 0);
    cycle("t5_ld00", 0, 0, 1, 0, 'h00);
    cycle("t5_dnff", 1, 1, 0, 0, 0);
    cycle("t5_ldfe", 0, 0, 1, 2, 'hFE);
    cycle("t5_up1", 1, 0, 0, 0, 0);
    cycle("t5_up2", 1, 0, 0, 0, 0);

    cycle("t6_ld2", 0, 0, 1, 2, 2);
    for (int i = 0; i < 4; i++) cycle("t6_up", 1, 0, 0, 0, 0);
    cycle("t6_ld0", 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cycle("t6_down", 1, 1, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) async_reset("rnd");
      else cycle("rnd", $urandom_range(0, 9) < 7, $urandom_range(0, 1),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 3),
                 $urandom_range(0, 255));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
